// File: rtl/islip_pkg.sv
// Shared types and constants for the 4x4 single-iteration iSLIP scheduler.
package islip_pkg;

    localparam int unsigned PORT_NUM = 4;

    localparam logic [3:0] ARB_STATE_IDLE = 4'd1;
    localparam logic [3:0] ARB_STATE_GRNT = 4'd2;
    localparam logic [3:0] ARB_STATE_ACPT = 4'd4;
    localparam logic [3:0] ARB_STATE_WAIT = 4'd8;

    typedef logic [PORT_NUM-1:0] port_vec_t;
    typedef port_vec_t port_arr_t [PORT_NUM];

    function automatic logic [1:0] oh2idx(input port_vec_t oh);
        logic [1:0] idx;
        idx = '0;
        for (int k = 0; k < int'(PORT_NUM); k++) begin
            if (oh[k]) idx = 2'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/islip_arbiter_rr_arb4.sv
// 4-way round-robin picker: one-hot grant to the first request at or after ptr_i.
module rr_arb4 (
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [3:0] gnt_o
);

    logic       found;
    logic [1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_i + 2'(k);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/islip_arbiter.sv
// Single-iteration iSLIP scheduler, 4x4, with valid/ready on both sides.
// Optional feature: ISLIP_TX_RDY_MASK_EN masks outputs whose tx_rdy_vect bit is low.
module islip_arbiter
    import islip_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       arb_valid_in,
    input  logic [3:0] rx_req_vect [PORT_NUM],
    input  logic [3:0] tx_rdy_vect,
    input  logic       arb_ready_out,
    output logic       arb_ready_in,
    output logic       arb_valid_out,
    output logic [3:0] arb_vect [PORT_NUM]
);

    logic [3:0] state_q, state_d;
    port_arr_t  req_q;
    port_arr_t  grant_q;        // indexed by output: one-hot granted input
    port_arr_t  vect_q, vect_d;
    logic [1:0] g_q [PORT_NUM];
    logic [1:0] g_d [PORT_NUM];
    logic [1:0] a_q [PORT_NUM];
    logic [1:0] a_d [PORT_NUM];

    port_vec_t  elig;
    port_arr_t  gnt_req, gnt_oh, acc_req, acc_oh;
    logic [1:0] acc_idx;

`ifdef ISLIP_TX_RDY_MASK_EN
    assign elig = tx_rdy_vect;
`else
    logic unused_tx_rdy;
    assign unused_tx_rdy = ^tx_rdy_vect;
    assign elig = 4'hF;
`endif

    // Transpose the request matrix for the grant side and the grants for the accept side.
    always_comb begin
        for (int j = 0; j < int'(PORT_NUM); j++) begin
            for (int i = 0; i < int'(PORT_NUM); i++) begin
                gnt_req[j][i] = req_q[i][j] & elig[j];
                acc_req[i][j] = grant_q[j][i];
            end
        end
    end

    for (genvar k = 0; k < PORT_NUM; k++) begin : g_arb
        rr_arb4 u_grant (
            .req_i (gnt_req[k]),
            .ptr_i (g_q[k]),
            .gnt_o (gnt_oh[k])
        );
        rr_arb4 u_accept (
            .req_i (acc_req[k]),
            .ptr_i (a_q[k]),
            .gnt_o (acc_oh[k])
        );
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_STATE_IDLE: if (arb_valid_in) state_d = ARB_STATE_GRNT;
            ARB_STATE_GRNT: state_d = ARB_STATE_ACPT;
            ARB_STATE_ACPT: state_d = ARB_STATE_WAIT;
            ARB_STATE_WAIT: if (arb_ready_out) state_d = ARB_STATE_IDLE;
            default:        state_d = ARB_STATE_IDLE;
        endcase
    end

    // Pointers move only for accepted grants.
    always_comb begin
        g_d     = g_q;
        a_d     = a_q;
        vect_d  = vect_q;
        acc_idx = '0;
        if (state_q == ARB_STATE_ACPT) begin
            for (int i = 0; i < int'(PORT_NUM); i++) begin
                vect_d[i] = acc_oh[i];
                if (|acc_oh[i]) begin
                    acc_idx      = oh2idx(acc_oh[i]);
                    a_d[i]       = acc_idx + 2'd1;
                    g_d[acc_idx] = 2'(i + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_STATE_IDLE;
            for (int k = 0; k < int'(PORT_NUM); k++) begin
                req_q[k]   <= '0;
                grant_q[k] <= '0;
                vect_q[k]  <= '0;
                g_q[k]     <= '0;
                a_q[k]     <= '0;
            end
        end else begin
            state_q <= state_d;
            if (state_q == ARB_STATE_IDLE && arb_valid_in) req_q <= rx_req_vect;
            if (state_q == ARB_STATE_GRNT) grant_q <= gnt_oh;
            vect_q <= vect_d;
            g_q    <= g_d;
            a_q    <= a_d;
        end
    end

    assign arb_ready_in  = (state_q == ARB_STATE_IDLE) & ~rst;
    assign arb_valid_out = (state_q == ARB_STATE_WAIT);
    assign arb_vect      = vect_q;

endmodule

// File: tb/tb_islip_arbiter.sv
// Bench for islip_arbiter: round-level iSLIP model plus directed rounds with literal results.
module tb_islip_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       arb_valid_in;
    logic [3:0] rx_req_vect [4];
    logic [3:0] tx_rdy_vect;
    logic       arb_ready_out;
    logic       arb_ready_in;
    logic       arb_valid_out;
    logic [3:0] arb_vect [4];

    int checks = 0;
    int errors = 0;

    islip_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .arb_valid_in  (arb_valid_in),
        .rx_req_vect   (rx_req_vect),
        .tx_rdy_vect   (tx_rdy_vect),
        .arb_ready_out (arb_ready_out),
        .arb_ready_in  (arb_ready_in),
        .arb_valid_out (arb_valid_out),
        .arb_vect      (arb_vect)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][3:0] v;
        logic [3:0][1:0] g;
        logic [3:0][1:0] a;
    } match_t;

    // Model: phase 0 idle, 1 grant, 2 accept, 3 result presented.
    int              phase;
    logic [3:0][3:0] m_req;
    logic [3:0][3:0] m_vect;
    logic [3:0][1:0] m_g;
    logic [3:0][1:0] m_a;
    logic [3:0]      m_elig;

    function automatic match_t model_match(input logic [3:0][3:0] req, input logic [3:0][1:0] g,
                                           input logic [3:0][1:0] a, input logic [3:0] elig);
        match_t r;
        int     gi [4];
        bit     taken;
        r.v = '0;
        r.g = g;
        r.a = a;
        for (int j = 0; j < 4; j++) begin
            gi[j] = -1;
            if (elig[j]) begin
                for (int k = 0; k < 4; k++) begin
                    int i;
                    i = (int'(g[j]) + k) % 4;
                    if (gi[j] < 0 && req[i][j]) gi[j] = i;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            taken = 1'b0;
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (int'(a[i]) + k) % 4;
                if (!taken && gi[j] == i) begin
                    taken     = 1'b1;
                    r.v[i][j] = 1'b1;
                    r.a[i]    = 2'((j + 1) % 4);
                    r.g[j]    = 2'((i + 1) % 4);
                end
            end
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            phase  <= 0;
            m_vect <= '0;
            m_g    <= '0;
            m_a    <= '0;
            m_req  <= '0;
            m_elig <= '0;
        end else begin
            case (phase)
                0: if (arb_valid_in) begin
                    m_req <= {rx_req_vect[3], rx_req_vect[2], rx_req_vect[1], rx_req_vect[0]};
                    phase <= 1;
                end
                1: begin
`ifdef ISLIP_TX_RDY_MASK_EN
                    m_elig <= tx_rdy_vect;
`else
                    m_elig <= 4'hF;
`endif
                    phase <= 2;
                end
                2: begin
                    match_t r;
                    r = model_match(m_req, m_g, m_a, m_elig);
                    m_vect <= r.v;
                    m_g    <= r.g;
                    m_a    <= r.a;
                    phase  <= 3;
                end
                default: if (arb_ready_out) phase <= 0;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] dut_vect();
        return {arb_vect[3], arb_vect[2], arb_vect[1], arb_vect[0]};
    endfunction

    always @(negedge clk) begin
        check("ready_in", 32'(arb_ready_in), 32'(phase == 0 && rst === 1'b0));
        check("valid_out", 32'(arb_valid_out), 32'(phase == 3 && rst === 1'b0));
        check("vect", 32'(dut_vect()), 32'(m_vect));
    end

    task automatic run_round(input logic [3:0] r0, input logic [3:0] r1,
                             input logic [3:0] r2, input logic [3:0] r3);
        bit seen;
        @(negedge clk);
        rx_req_vect[0] = r0;
        rx_req_vect[1] = r1;
        rx_req_vect[2] = r2;
        rx_req_vect[3] = r3;
        arb_valid_in   = 1'b1;
        @(negedge clk);
        arb_valid_in = 1'b0;
        // Scramble requests after capture; they must not affect this round.
        for (int k = 0; k < 4; k++) rx_req_vect[k] = 4'($urandom);
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (arb_valid_out) seen = 1'b1;
        end
        if (!seen) check("round_timeout", 32'd0, 32'd1);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_valid", 32'(arb_valid_out), 32'd0);
        check("async_ready", 32'(arb_ready_in), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        logic [15:0] saved;
        int          xfers;
        int          cnt;
        rst           = 1'b1;
        arb_valid_in  = 1'b0;
        arb_ready_out = 1'b1;
        tx_rdy_vect   = 4'hF;
        for (int k = 0; k < 4; k++) rx_req_vect[k] = '0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("reset_vect", 32'(dut_vect()), 32'h0);

        // Reset while the result is presented; pointers must return to 0.
        arb_ready_out = 1'b0;
        run_round(4'h0, 4'h1, 4'hC, 4'h0);
        check("pre_reset_vect", 32'(dut_vect()), 32'h0410);
        #2 rst = 1'b1;
        #1;
        check("async_valid_wait", 32'(arb_valid_out), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        arb_ready_out = 1'b1;
        @(negedge clk);
        check("post_reset_vect", 32'(dut_vect()), 32'h0);

        run_round(4'h0, 4'h1, 4'hC, 4'h0);
        check("round1_vect", 32'(dut_vect()), 32'h0410);
        run_round(4'h0, 4'h1, 4'hC, 4'h0);
        check("round2_rotate", 32'(dut_vect()), 32'h0810);

        reset_pulse();
        run_round(4'h7, 4'h2, 4'h8, 4'h2);
        check("conflict_vect", 32'(dut_vect()), 32'h0801);
        for (int j = 0; j < 4; j++) begin
            cnt = 0;
            for (int i = 0; i < 4; i++) if (arb_vect[i][j]) cnt++;
            check("output_unique", 32'(cnt <= 1), 32'd1);
        end

        // Back-pressure: result held for 5 cycles, then exactly one transfer.
        arb_ready_out = 1'b0;
        run_round(4'h2, 4'h1, 4'h8, 4'h4);
        saved = dut_vect();
        repeat (5) begin
            @(negedge clk);
            check("hold_stable", 32'(dut_vect()), 32'(saved));
            check("hold_ready_in", 32'(arb_ready_in), 32'd0);
        end
        arb_ready_out = 1'b1;
        xfers = 0;
        for (int n = 0; n < 4; n++) begin
            if (n > 0) @(negedge clk);
            if (arb_valid_out && arb_ready_out) xfers++;
        end
        check("one_transfer", 32'(xfers), 32'd1);
        check("back_to_idle", 32'(arb_ready_in), 32'd1);

        reset_pulse();
        tx_rdy_vect = 4'h0;
        run_round(4'h6, 4'h1, 4'h0, 4'h0);
`ifdef ISLIP_TX_RDY_MASK_EN
        check("masked_vect", 32'(dut_vect()), 32'h0);
`else
        check("unmasked_vect", 32'(dut_vect()), 32'h0012);
`endif
        tx_rdy_vect = 4'hF;
        run_round(4'h6, 4'h1, 4'h0, 4'h0);
`ifdef ISLIP_TX_RDY_MASK_EN
        check("ready_vect", 32'(dut_vect()), 32'h0012);
`else
        check("ready_vect", 32'(dut_vect()), 32'h0014);
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
